// File: rtl/fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : fft_out_reorder
//  Purpose  : Output stage behind the 4-lane parallel FFT. Frames arrive in
//             bit-reversed order, 4 bins per beat. Each beat is scattered into
//             one bank of a ping-pong register buffer at bit-reversed
//             addresses. Each completed frame is streamed back out in natural
//             order, 4 bins per beat.
//  Ports    : clk, rst      - clock, synchronous active-high reset
//             in_valid/in_ready/in_data/in_sof
//                           - input beat stream; lane l of in_data is
//                             in_data[l*W +: W]
//             out_valid/out_ready/out_data/out_last
//                           - registered natural-order output stream; lane l
//                             of beat k is natural bin 4*k+l
//             ovf           - sticky framing / overrun flag, cleared by rst
//  Revision : 1.0  initial release
// ============================================================================
module fft_out_reorder #(
    parameter int N     = 128,
    parameter int W     = 15,
    parameter int LOG2N = 7
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [4*W-1:0] in_data,
    input  logic           in_sof,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [4*W-1:0] out_data,
    output logic           out_last,
    output logic           ovf
);

    localparam int              c_CW        = LOG2N - 2;
    localparam logic [c_CW-1:0] c_LAST_BEAT = c_CW'(N / 4 - 1);

    localparam logic [1:0] c_EMPTY    = 2'd0;
    localparam logic [1:0] c_FILLING  = 2'd1;
    localparam logic [1:0] c_FULL     = 2'd2;
    localparam logic [1:0] c_DRAINING = 2'd3;

    function automatic logic [LOG2N-1:0] f_bitrev(input logic [LOG2N-1:0] a);
        logic [LOG2N-1:0] r;
        for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
        return r;
    endfunction

    // Storage and state
    logic [W-1:0]    r_mem [2][N];
    logic [1:0]      r_state [2];
    logic [1:0]      w_state_nxt [2];
    logic            r_wr_bank;
    logic [c_CW-1:0] r_wr_cnt;
    logic            r_rd_bank;     // bank being drained, or next to drain
    logic [c_CW-1:0] r_rd_cnt;      // beat index currently held in the output register
    logic            r_out_valid;
    logic [4*W-1:0]  r_out_data;
    logic            r_out_last;
    logic            r_ovf;

    // Control decode
    logic            w_in_ready;
    logic            w_wr_fire;
    logic            w_sof_restart;
    logic [c_CW-1:0] w_wr_idx;
    logic            w_wr_last;
    logic            w_out_adv;
    logic            w_last_hs;
    logic            w_more;
    logic            w_rd_sel;
    logic            w_start;
    logic            w_load;
    logic [c_CW-1:0] w_next_beat;
    logic [4*W-1:0]  w_rd_data;

    // ------------------------------------------------------------------
    // Bank state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state[0] <= c_EMPTY;
            r_state[1] <= c_EMPTY;
        end else begin
            r_state[0] <= w_state_nxt[0];
            r_state[1] <= w_state_nxt[1];
        end
    end

    // ------------------------------------------------------------------
    // Bank next-state logic. Later assignments win: a bank that receives
    // its final beat and is picked for draining in the same cycle goes
    // straight to DRAINING.
    // ------------------------------------------------------------------
    always_comb begin
        for (int b = 0; b < 2; b++) begin
            w_state_nxt[b] = r_state[b];
            if (w_wr_fire && (r_wr_bank == 1'(b)))
                w_state_nxt[b] = w_wr_last ? c_FULL : c_FILLING;
            if (w_start && (w_rd_sel == 1'(b)))
                w_state_nxt[b] = c_DRAINING;
            if (w_last_hs && (r_rd_bank == 1'(b)))
                w_state_nxt[b] = c_EMPTY;
        end
    end

    // ------------------------------------------------------------------
    // Control outputs derived from the bank states
    // ------------------------------------------------------------------
    always_comb begin
        w_in_ready    = !((r_state[r_wr_bank] == c_FULL) ||
                          (r_state[r_wr_bank] == c_DRAINING));
        w_wr_fire     = in_valid && w_in_ready;
        // A start-of-frame mid-frame discards the partial frame and is
        // itself written as beat 0.
        w_sof_restart = in_sof && (r_wr_cnt != '0);
        w_wr_idx      = w_sof_restart ? '0 : r_wr_cnt;
        w_wr_last     = w_wr_fire && (w_wr_idx == c_LAST_BEAT);

        w_out_adv     = !r_out_valid || out_ready;
        w_last_hs     = r_out_valid && out_ready && r_out_last;
        w_more        = r_out_valid && !r_out_last;
        // Once out_last is taken the other bank is the next frame in order.
        w_rd_sel      = w_last_hs ? ~r_rd_bank : r_rd_bank;
        // A bank receiving its final beat this cycle may start at once;
        // the missing bins come from the write bypass below.
        w_start       = w_out_adv && !w_more &&
                        ((r_state[w_rd_sel] == c_FULL) ||
                         (w_wr_last && (r_wr_bank == w_rd_sel)));
        w_load        = w_out_adv && (w_more || w_start);
        w_next_beat   = w_more ? c_CW'(r_rd_cnt + c_CW'(1)) : '0;
    end

    // Natural-order read with bypass from the beat being written this cycle
    always_comb begin
        w_rd_data = '0;
        for (int l = 0; l < 4; l++) begin
            w_rd_data[l*W +: W] = r_mem[w_rd_sel][{w_next_beat, 2'(l)}];
            for (int m = 0; m < 4; m++) begin
                if (w_wr_fire && (r_wr_bank == w_rd_sel) &&
                    (f_bitrev({w_wr_idx, 2'(m)}) == {w_next_beat, 2'(l)}))
                    w_rd_data[l*W +: W] = in_data[m*W +: W];
            end
        end
    end

    // ------------------------------------------------------------------
    // Write side: counter, bank pointer, overflow flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_bank <= 1'b0;
            r_wr_cnt  <= '0;
            r_ovf     <= 1'b0;
        end else begin
            if (w_wr_fire) begin
                if (w_wr_last) begin
                    r_wr_cnt  <= '0;
                    r_wr_bank <= ~r_wr_bank;
                end else begin
                    r_wr_cnt  <= c_CW'(w_wr_idx + c_CW'(1));
                end
            end
            if ((in_valid && !w_in_ready) || (w_wr_fire && w_sof_restart))
                r_ovf <= 1'b1;
        end
    end

    // Bin storage, scattered at bit-reversed addresses
    always_ff @(posedge clk) begin
        if (w_wr_fire) begin
            for (int l = 0; l < 4; l++)
                r_mem[r_wr_bank][f_bitrev({w_wr_idx, 2'(l)})] <= in_data[l*W +: W];
        end
    end

    // ------------------------------------------------------------------
    // Read side: registered output beat
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_bank   <= 1'b0;
            r_rd_cnt    <= '0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_last_hs)
                r_rd_bank <= ~r_rd_bank;
            if (w_out_adv) begin
                r_out_valid <= w_load;
                if (w_load) begin
                    r_rd_cnt   <= w_next_beat;
                    r_out_data <= w_rd_data;
                    r_out_last <= (w_next_beat == c_LAST_BEAT);
                end else begin
                    r_out_last <= 1'b0;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_last  = r_out_last;
    assign ovf       = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_fft_out_reorder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fft_out_reorder
//  Purpose  : Self-checking bench for fft_out_reorder (N=16, W=15). Frames are
//             built in natural order, sent in bit-reversed stream order, and
//             the output is compared against the natural-order frame.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fft_out_reorder;
    localparam int N     = 16;
    localparam int W     = 15;
    localparam int LOG2N = 4;
    localparam int NB    = N / 4;
    localparam int DW    = 4 * W;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_sof;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          ovf;

    fft_out_reorder #(.N(N), .W(W), .LOG2N(LOG2N)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sof(in_sof),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct { logic [DW-1:0] data; logic sof; logic eof; } ibeat_t;
    typedef struct { logic [DW-1:0] data; logic last; int cyc; } obeat_t;

    ibeat_t        in_q [$];
    obeat_t        got_q[$];
    logic [DW-1:0] exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;
    bit rand_in, rand_out;
    int ready_low;
    int first_valid_cyc, last_in_cyc, in_blocked, stall_viol, sim_events;
    int acc_cnt, acc_before_block;

    function automatic int bitrev(input int s);
        int r = 0;
        for (int b = 0; b < LOG2N; b++)
            if (((s >> b) & 1) != 0) r = r | (1 << (LOG2N - 1 - b));
        return r;
    endfunction

    // Natural-order frame -> bit-reversed input beats; optional expected beats
    task automatic add_frame(input bit natural_vals, input bit expect_it);
        logic [W-1:0]  nat [N];
        logic [DW-1:0] d;
        for (int j = 0; j < N; j++) nat[j] = natural_vals ? W'(j) : W'($urandom);
        for (int c = 0; c < NB; c++) begin
            d = '0;
            for (int l = 0; l < 4; l++) d[l*W +: W] = nat[bitrev(4*c + l)];
            in_q.push_back('{d, (c == 0), (c == NB-1)});
        end
        if (expect_it) begin
            for (int k = 0; k < NB; k++) begin
                d = '0;
                for (int l = 0; l < 4; l++) d[l*W +: W] = nat[4*k + l];
                exp_q.push_back(d);
            end
        end
    endtask

    task automatic add_partial(input int beats);
        for (int c = 0; c < beats; c++)
            in_q.push_back('{DW'({$urandom, $urandom}), (c == 0), 1'b0});
    endtask

    task automatic clear_all();
        in_q.delete(); got_q.delete(); exp_q.delete();
        rand_in = 0; rand_out = 0; ready_low = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; in_valid = 1'b0; in_sof = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Cycle engine: drives queued beats, collects output handshakes
    task automatic run_engine(input int want, input int max_cycles, input int tail);
        int  n = 0, tl = 0;
        bit  hs_in, hs_out, stall;
        logic [DW-1:0] pd;
        logic pl;
        first_valid_cyc = -1; last_in_cyc = -1; in_blocked = 0; stall_viol = 0;
        sim_events = 0; acc_cnt = 0; acc_before_block = -1;
        while (n < max_cycles) begin
            if (in_q.size() == 0 && got_q.size() >= want) begin
                if (tl >= tail) break;
                tl++;
            end
            if (in_q.size() != 0 && (!rand_in || $urandom_range(0, 2) != 0)) begin
                in_valid = 1'b1; in_data = in_q[0].data; in_sof = in_q[0].sof;
            end else begin
                in_valid = 1'b0; in_data = '0; in_sof = 1'b0;
            end
            out_ready = (n < ready_low) ? 1'b0 : (rand_out ? ($urandom_range(0, 3) != 0) : 1'b1);
            #1;
            hs_in  = in_valid && in_ready;
            hs_out = out_valid && out_ready;
            if (in_valid && !in_ready) begin
                in_blocked++;
                if (acc_before_block < 0) acc_before_block = acc_cnt;
            end
            if (hs_in && in_q[0].eof) last_in_cyc = cyc;
            if (hs_in && in_q[0].eof && hs_out && out_last) sim_events++;
            stall = out_valid && !out_ready;
            pd = out_data; pl = out_last;
            if (hs_out) got_q.push_back('{out_data, out_last, cyc});
            @(posedge clk); #1;
            cyc++; n++;
            if (hs_in) begin void'(in_q.pop_front()); acc_cnt++; end
            if (stall && (!out_valid || out_data !== pd || out_last !== pl)) stall_viol++;
            if (out_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
        end
        in_valid = 1'b0; in_sof = 1'b0;
    endtask

    task automatic test_reset();
        n_checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (out_data !== '0) $display("FAIL reset_out_data: got %h expected 0", out_data); else n_pass++;
        n_checks++; if (out_last !== 1'b0) $display("FAIL reset_out_last: got %b expected 0", out_last); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL reset_ovf: got %b expected 0", ovf); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b expected 1", in_ready); else n_pass++;
    endtask

    task automatic test_single();
        clear_all(); do_reset();
        add_frame(1'b1, 1'b1);
        run_engine(NB, 100, 6);
        n_checks++; if (got_q.size() != NB) $display("FAIL single_count: got %0d expected %0d", got_q.size(), NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL single_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
            n_checks++; if (got_q[i].last !== (i % NB == NB-1)) $display("FAIL single_last[%0d]: got %b expected %b", i, got_q[i].last, (i % NB == NB-1)); else n_pass++;
        end
        n_checks++; if (first_valid_cyc != last_in_cyc + 1) $display("FAIL single_latency: got first valid at %0d expected %0d", first_valid_cyc, last_in_cyc + 1); else n_pass++;
    endtask

    task automatic test_back_to_back();
        int gaps = 0;
        clear_all(); do_reset();
        repeat (3) add_frame(1'b0, 1'b1);
        run_engine(3*NB, 200, 6);
        n_checks++; if (got_q.size() != 3*NB) $display("FAIL b2b_count: got %0d expected %0d", got_q.size(), 3*NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL b2b_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
            n_checks++; if (got_q[i].last !== (i % NB == NB-1)) $display("FAIL b2b_last[%0d]: got %b expected %b", i, got_q[i].last, (i % NB == NB-1)); else n_pass++;
            if (got_q[i].cyc != got_q[0].cyc + i) gaps++;
        end
        n_checks++; if (gaps != 0) $display("FAIL b2b_contiguous: got %0d gaps expected 0", gaps); else n_pass++;
        n_checks++; if (in_blocked != 0) $display("FAIL b2b_in_ready: got %0d blocked cycles expected 0", in_blocked); else n_pass++;
        n_checks++; if (ovf !== 1'b0) $display("FAIL b2b_ovf: got %b expected 0", ovf); else n_pass++;
    endtask

    task automatic test_backpressure();
        clear_all(); do_reset();
        repeat (3) add_frame(1'b0, 1'b1);
        ready_low = 20;
        run_engine(3*NB, 300, 6);
        n_checks++; if (got_q.size() != 3*NB) $display("FAIL bp_count: got %0d expected %0d", got_q.size(), 3*NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL bp_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
            n_checks++; if (got_q[i].last !== (i % NB == NB-1)) $display("FAIL bp_last[%0d]: got %b expected %b", i, got_q[i].last, (i % NB == NB-1)); else n_pass++;
        end
        n_checks++; if (acc_before_block != 2*NB) $display("FAIL bp_in_ready_fall: got block after %0d beats expected %0d", acc_before_block, 2*NB); else n_pass++;
        n_checks++; if (stall_viol != 0) $display("FAIL bp_stall_stable: got %0d changes expected 0", stall_viol); else n_pass++;
        n_checks++; if (ovf !== 1'b1) $display("FAIL bp_ovf: got %b expected 1", ovf); else n_pass++;
    endtask

    task automatic test_mid_sof();
        clear_all(); do_reset();
        add_partial(2);
        add_frame(1'b0, 1'b1);
        add_frame(1'b0, 1'b1);
        run_engine(2*NB, 200, 6);
        n_checks++; if (got_q.size() != 2*NB) $display("FAIL sof_count: got %0d expected %0d", got_q.size(), 2*NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL sof_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
            n_checks++; if (got_q[i].last !== (i % NB == NB-1)) $display("FAIL sof_last[%0d]: got %b expected %b", i, got_q[i].last, (i % NB == NB-1)); else n_pass++;
        end
        n_checks++; if (ovf !== 1'b1) $display("FAIL sof_ovf: got %b expected 1", ovf); else n_pass++;
    endtask

    task automatic test_reset_mid_drain();
        clear_all(); do_reset();
        add_frame(1'b0, 1'b1);
        run_engine(1, 100, 0);
        n_checks++; if (out_valid !== 1'b1 || out_data !== exp_q[1]) $display("FAIL rmd_beat2: got v=%b %h expected v=1 %h", out_valid, out_data, exp_q[1]); else n_pass++;
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0) $display("FAIL rmd_out_valid: got %b expected 0", out_valid); else n_pass++;
        n_checks++; if (in_ready !== 1'b1) $display("FAIL rmd_in_ready: got %b expected 1", in_ready); else n_pass++;
        exp_q.delete(); got_q.delete();
        add_frame(1'b0, 1'b1);
        run_engine(NB, 100, 6);
        n_checks++; if (got_q.size() != NB) $display("FAIL rmd_count: got %0d expected %0d", got_q.size(), NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL rmd_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_simultaneous();
        int gaps = 0;
        clear_all(); do_reset();
        repeat (2) add_frame(1'b0, 1'b1);
        run_engine(2*NB, 200, 6);
        n_checks++; if (sim_events != 1) $display("FAIL sim_boundary_events: got %0d expected 1", sim_events); else n_pass++;
        n_checks++; if (got_q.size() != 2*NB) $display("FAIL sim_count: got %0d expected %0d", got_q.size(), 2*NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL sim_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
            if (got_q[i].cyc != got_q[0].cyc + i) gaps++;
        end
        n_checks++; if (gaps != 0) $display("FAIL sim_contiguous: got %0d gaps expected 0", gaps); else n_pass++;
        n_checks++; if (in_blocked != 0) $display("FAIL sim_in_ready: got %0d blocked cycles expected 0", in_blocked); else n_pass++;
    endtask

    task automatic test_random();
        clear_all(); do_reset();
        rand_in = 1; rand_out = 1;
        repeat (6) add_frame(1'b0, 1'b1);
        run_engine(6*NB, 600, 8);
        n_checks++; if (got_q.size() != 6*NB) $display("FAIL rnd_count: got %0d expected %0d", got_q.size(), 6*NB); else n_pass++;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            n_checks++; if (got_q[i].data !== exp_q[i]) $display("FAIL rnd_data[%0d]: got %h expected %h", i, got_q[i].data, exp_q[i]); else n_pass++;
            n_checks++; if (got_q[i].last !== (i % NB == NB-1)) $display("FAIL rnd_last[%0d]: got %b expected %b", i, got_q[i].last, (i % NB == NB-1)); else n_pass++;
        end
        n_checks++; if (stall_viol != 0) $display("FAIL rnd_stall_stable: got %0d changes expected 0", stall_viol); else n_pass++;
    endtask

    initial begin
        clear_all();
        do_reset();
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_mid_sof();
        test_reset_mid_drain();
        test_simultaneous();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
